// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
// Comb-only content: no latency, no flow control.
package arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Callers pass a one-hot (or zero) vector; zero yields index 0.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority find-first-set over N requests, starting at ptr.
// Purely combinational; ptr tied to 0 gives plain fixed priority.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    pick_oh,
  output logic [IDXW-1:0] pick_idx,
  output logic            pick_any
);

  logic [31:0] w_oh32;

  always_comb begin
    int j;
    logic [IDXW-1:0] idx;
    pick_oh  = '0;
    pick_any = 1'b0;
    j        = 0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = IDXW'(j);
      if (!pick_any && req[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_any     = 1'b1;
      end
    end
  end

  always_comb begin
    w_oh32         = '0;
    w_oh32[N-1:0]  = pick_oh;
  end

  assign pick_idx = IDXW'(onehot_to_idx(w_oh32));

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-way arbiter, fixed or round-robin priority, registered one-hot grant held until done/withdrawal.
// Latency: req->gnt 1 cycle, release->gnt low 1 cycle, then a forced idle bubble; no preemption.
module prio_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int RR_MODE = 0,
  parameter int IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  if (N < 2 || N > 32 || IDXW != $clog2(N)) begin : g_bad_param
    $error("prio_rr_arbiter: N must be 2..32 and IDXW left at its default");
  end

  arb_state_e      r_state;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;
  logic [IDXW-1:0] r_gnt_idx;
  logic [IDXW-1:0] r_rr_ptr;

  logic [IDXW-1:0] w_ptr;
  logic [N-1:0]    w_pick_oh;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_any;
  logic            w_release;
  logic [IDXW-1:0] w_next_ptr;

  assign w_ptr = (RR_MODE == ARB_RR) ? r_rr_ptr : '0;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req      (req),
    .ptr      (w_ptr),
    .pick_oh  (w_pick_oh),
    .pick_idx (w_pick_idx),
    .pick_any (w_pick_any)
  );

  assign w_release  = (r_state == ARB_GRANT) && (done || !req[r_gnt_idx]);
  assign w_next_ptr = (r_gnt_idx == IDXW'(N - 1)) ? '0 : r_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_gnt       <= w_pick_oh;
            r_gnt_idx   <= w_pick_idx;
            r_gnt_valid <= 1'b1;
            r_state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // Returning through IDLE is what creates the one-cycle bubble.
          if (w_release) begin
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= ARB_IDLE;
            if (RR_MODE == ARB_RR) r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
  a_idx    : assert property (@(posedge clk) disable iff (rst) gnt[gnt_idx] == gnt_valid);

  always @(posedge clk) begin
    if (!rst && r_state == ARB_IDLE) begin
      a_req_known : assert (!$isunknown(req)) else $warning("arbiter req unknown");
    end
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed checks of fixed-priority, round-robin (N=4 and N=8), release, withdrawal and reset.
module tb_prio_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_f, req_r;
  logic [7:0] req_8;
  logic       done_f, done_r, done_8;
  logic [3:0] gnt_f, gnt_r;
  logic [7:0] gnt_8;
  logic       vld_f, vld_r, vld_8;
  logic [1:0] idx_f, idx_r;
  logic [2:0] idx_8;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt8 [8];

  always #5 clk = ~clk;

  prio_rr_arbiter #(.N(4), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req_f), .done(done_f),
    .gnt(gnt_f), .gnt_valid(vld_f), .gnt_idx(idx_f));

  prio_rr_arbiter #(.N(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r), .done(done_r),
    .gnt(gnt_r), .gnt_valid(vld_r), .gnt_idx(idx_r));

  prio_rr_arbiter #(.N(8), .RR_MODE(1)) u_rr8 (
    .clk(clk), .rst(rst), .req(req_8), .done(done_8),
    .gnt(gnt_8), .gnt_valid(vld_8), .gnt_idx(idx_8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq4 [5];
    seq4[0] = 4'b0001; seq4[1] = 4'b0010; seq4[2] = 4'b0100;
    seq4[3] = 4'b1000; seq4[4] = 4'b0001;
    for (int i = 0; i < 8; i++) cnt8[i] = 0;

    rst = 1'b1;
    req_f = '0; req_r = '0; req_8 = '0;
    done_f = 1'b0; done_r = 1'b0; done_8 = 1'b0;
    tick(); tick();
    chk("rst_gnt",   32'(gnt_f), 0);
    chk("rst_vld",   32'(vld_f), 0);
    chk("rst_idx",   32'(idx_f), 0);
    chk("rst_rr_gnt", 32'(gnt_r), 0);
    chk("rst_ptr",   32'(u_rr.r_rr_ptr), 0);
    rst = 1'b0;

    // Fixed priority: lowest index wins, no preemption once granted.
    req_f = 4'b0110;
    tick();
    chk("fix_gnt",  32'(gnt_f), 32'b0010);
    chk("fix_idx",  32'(idx_f), 1);
    chk("fix_vld",  32'(vld_f), 1);
    req_f = 4'b0111;
    tick();
    chk("fix_hold", 32'(gnt_f), 32'b0010);
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    chk("fix_rel_gnt", 32'(gnt_f), 0);
    chk("fix_rel_vld", 32'(vld_f), 0);
    tick();
    chk("fix_regnt",   32'(gnt_f), 32'b0001);
    chk("fix_regnt_idx", 32'(idx_f), 0);
    req_f = 4'b0000;
    tick();
    chk("fix_wd_gnt", 32'(gnt_f), 0);
    chk("fix_ptr",    32'(u_fix.r_rr_ptr), 0);
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    chk("fix_done_idle", 32'(gnt_f), 0);

    // Round robin N=4, all requesting: 0,1,2,3,0 with a zero cycle between.
    req_r = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_seq%0d", i), 32'(gnt_r), 32'(seq4[i]));
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
      chk($sformatf("rr_bub%0d", i), 32'(gnt_r), 0);
      tick();
    end
    chk("rr_own1", 32'(gnt_r), 32'b0010);

    // Sparse: release owner 1 -> ptr 2; req 0011 wraps around to index 0.
    req_r = 4'b0011;
    done_r = 1'b1;
    tick();
    done_r = 1'b0;
    chk("rr_ptr2", 32'(u_rr.r_rr_ptr), 2);
    tick();
    chk("rr_wrap_gnt", 32'(gnt_r), 32'b0001);
    done_r = 1'b1;
    tick();
    done_r = 1'b0;
    chk("rr_ptr1", 32'(u_rr.r_rr_ptr), 1);

    // Withdrawal by owner 2 without done.
    req_r = 4'b0100;
    tick();
    chk("rr_gnt2", 32'(gnt_r), 32'b0100);
    chk("rr_idx2", 32'(idx_r), 2);
    req_r = 4'b0000;
    tick();
    chk("rr_wd_gnt", 32'(gnt_r), 0);
    chk("rr_ptr3",   32'(u_rr.r_rr_ptr), 3);

    // Reset mid-grant.
    req_r = 4'b1000;
    tick();
    chk("rr_gnt3", 32'(gnt_r), 32'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(gnt_r), 0);
    chk("mid_rst_vld", 32'(vld_r), 0);
    chk("mid_rst_idx", 32'(idx_r), 0);
    chk("mid_rst_ptr", 32'(u_rr.r_rr_ptr), 0);
    tick();
    chk("post_rst_gnt", 32'(gnt_r), 32'b1000);
    req_r = 4'b0000;

    // Round robin N=8 over 16 grants: each index exactly twice, in order.
    req_8 = 8'hFF;
    tick();
    for (int g = 0; g < 16; g++) begin
      chk($sformatf("rr8_gnt%0d", g), 32'(gnt_8), 32'(1) << (g % 8));
      chk($sformatf("rr8_idx%0d", g), 32'(idx_8), 32'(g % 8));
      if (vld_8) cnt8[idx_8] = cnt8[idx_8] + 1;
      done_8 = 1'b1;
      tick();
      done_8 = 1'b0;
      tick();
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rr8_cnt%0d", i), 32'(cnt8[i]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
